message_schedule_seq: RTL and testbench
=======================================

// Module: message_schedule_seq
// PURPOSE
// - Sequencer and W-memory owner for the SHA-256 message schedule. Loads a
//   16-word block over a valid/ready input and drives round 0..63 to the
//   combinational schedule datapath. Serves that datapath's four read
//   addresses from a 64x32 W array, writes each returned word back at
//   W[round], and streams W[t] to the compression core over valid/ready.
// PARAMETERS
// - WIDTH        32  word width; only 32 is supported
// - BLOCK_WORDS  16  words loaded per block; rounds below this pass W through
// - ROUNDS       64  schedule length; address width is 6, ROUNDS must be <= 64
// PORTS
// - clk          in   1   clock; all state changes on rising edge
// - rst          in   1   synchronous, active-high reset
// - in_valid     in   1   input block word valid
// - in_ready     out  1   block-word accept; high only in LOAD
// - in_data      in   32  block word; big-endian word order, word 0 first
// - round        out  6   current round to schedule datapath
// - addr_a       in   6   read address a from datapath (W[t-15] or W[t])
// - addr_b       in   6   read address b (W[t-2])
// - addr_c       in   6   read address c (W[t-16])
// - addr_d       in   6   read address d (W[t-7])
// - a,b,c,d      out  32  combinational reads mem[addr_a..addr_d]
// - message      in   32  W[round] computed by datapath
// - w_valid      out  1   W word valid to compression core
// - w_ready      in   1   compression core accepts W word
// - w_data       out  32  W[w_round]
// - w_round      out  6   round index of w_data
// - w_last       out  1   high with w_valid on round ROUNDS-1
// BEHAVIOUR
// - Reset: state=LOAD, load_cnt=0, round=0, in_ready=1, w_valid=0,
//   w_last=0, w_data=0, w_round=0. W array contents are not reset.
// - LOAD: on in_valid&in_ready write mem[load_cnt]=in_data, load_cnt++.
//   Accepting word 15 -> RUN next cycle, load_cnt=0, round=0, in_ready=0.
// - RUN: w_valid=1, w_data=message, w_round=round. Reads a..d are
//   asynchronous, so the full loop (round -> addr -> data -> message) is
//   same-cycle. Throughput is 1 W/cycle when w_ready is held high.
// - Handshake: on w_valid&w_ready write mem[round]=message and round++.
//   Rounds < 16 rewrite the loaded word with the same value.
//   With w_ready=0: round, the array and w_data are held stable. A valid
//   word is never withdrawn.
// - Last: accepting round ROUNDS-1 (w_last=1) -> LOAD next cycle,
//   round=0, in_ready=1. No idle cycle between the last W and the new load.
// - Wrap: all 6-bit addresses are legal reads, including round-16 wrapping
//   for round < 16. Those words are unused by the datapath.
// - in_valid in RUN is ignored: no write, no count change.
// - Sync reset mid-RUN or mid-LOAD returns to LOAD on the next edge and
//   discards the partial block. A new 16-word load fully overwrites W[0..15].
// - Write ports: a single array write per cycle; LOAD and RUN are exclusive.
// CONFIGURATION
// - MSG_SEQ_OUTREG_EN defined: w_valid, w_data, w_round and w_last come from
//   a 1-entry output register.
//   - Capture and write-back happen when the register is empty or draining
//     (w_ready=1); round then increments. Output latency is +1 cycle and
//     throughput stays 1/cycle.
//   - LOAD may start while the final word is still held. Reset clears the
//     register.
// - MSG_SEQ_OUTREG_EN undefined: combinational output path as described above.
// TESTING
// - Reset asserted 2 cycles -> in_ready=1, w_valid=0, round=0, w_last=0.
// - Load "abc" block (0x61626380, 14x0, 0x00000018), w_ready=1 ->
//   stream W0=0x61626380, W15=0x00000018, W16=0x61626380,
//   W17=0x000F0000, W63=0x12B1EDEB with w_last=1. 64 beats in 64 cycles.
// - Same block, w_ready toggled every cycle -> identical W sequence;
//   w_data/w_round stable across every stalled cycle; 128 cycles total.
// - in_valid=1 with junk data throughout RUN -> W sequence unchanged;
//   in_ready stays 0 until the cycle after w_last.
// - rst pulsed at round 30 -> next cycle in_ready=1, w_valid=0, round=0;
//   then "abc" reload streams W63=0x12B1EDEB again.
// - Two blocks back-to-back -> second load begins the cycle after w_last;
//   second stream is correct with no residue from the first.

Source files
------------

// File: rtl/message_schedule_seq.sv
// message_schedule_seq: sequencer and W-memory owner for the SHA-256 message
// schedule. Loads a 16-word block, walks rounds 0..ROUNDS-1 through an external
// combinational schedule datapath, serves its four reads from a 64x32 W array,
// writes each returned word back at W[round] and streams W[t] out over
// valid/ready.
// Optional feature: define MSG_SEQ_OUTREG_EN to drive the W stream from a
// 1-entry output register (+1 cycle latency, still 1 word/cycle).
module message_schedule_seq #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int ROUNDS      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [5:0]       round,
    input  logic [5:0]       addr_a,
    input  logic [5:0]       addr_b,
    input  logic [5:0]       addr_c,
    input  logic [5:0]       addr_d,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] message,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [WIDTH-1:0] w_data,
    output logic [5:0]       w_round,
    output logic             w_last
);

    // The array spans the whole 6-bit address space so wrapped reads stay legal.
    localparam int DEPTH = 64;

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [5:0]       load_cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             load_fire;
    logic             load_done;
    logic             last_round;
    logic             advance;
    logic             mem_we;
    logic [5:0]       mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign load_fire  = (state == S_LOAD) && in_valid;
    assign load_done  = load_fire && (load_cnt == 6'(BLOCK_WORDS - 1));
    assign last_round = (round == 6'(ROUNDS - 1));

    // Asynchronous reads close the round -> address -> data -> message loop
    // inside one cycle.
    assign a = mem[addr_a];
    assign b = mem[addr_b];
    assign c = mem[addr_c];
    assign d = mem[addr_d];

`ifdef MSG_SEQ_OUTREG_EN
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [5:0]       out_round;
    logic             out_last;

    // A round is consumed whenever the output register is empty or draining.
    assign advance = (state == S_RUN) && (!out_valid || w_ready);

    // Output register: capture on advance, otherwise drop the word once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b1;
            out_data  <= message;
            out_round <= round;
            out_last  <= last_round;
        end else if (w_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign w_valid = out_valid;
    assign w_data  = out_data;
    assign w_round = out_round;
    assign w_last  = out_last;
`else
    // A round is consumed on the output handshake itself.
    assign advance = (state == S_RUN) && w_ready;

    assign w_valid = (state == S_RUN);
    assign w_data  = (state == S_RUN) ? message : '0;
    assign w_round = round;
    assign w_last  = (state == S_RUN) && last_round;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= S_LOAD;
        else     state <= state_next;
    end

    // Next-state, input handshake and the single array write port.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = round;
        mem_wdata  = message;
        case (state)
            S_LOAD: begin
                in_ready  = 1'b1;
                mem_we    = in_valid;
                mem_waddr = load_cnt;
                mem_wdata = in_data;
                if (load_done) state_next = S_RUN;
            end
            S_RUN: begin
                mem_we = advance;
                if (advance && last_round) state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Load counter and round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt <= '0;
            round    <= '0;
        end else begin
            if (load_fire) load_cnt <= load_done ? 6'd0 : load_cnt + 6'd1;
            if (advance)   round    <= last_round ? 6'd0 : round + 6'd1;
        end
    end

    // W array write; rounds below BLOCK_WORDS rewrite the loaded word unchanged.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; each block load fully
        // overwrites W[0..15] before any of it is read.
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_message_schedule_seq.sv
// Bench for message_schedule_seq: a behavioural SHA-256 schedule datapath
// closes the round/address/data loop, and a reference model computes W[0..63]
// directly from the block with the textbook recurrence.
module tb_message_schedule_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  round;
    logic [5:0]  addr_a, addr_b, addr_c, addr_d;
    logic [31:0] a, b, c, d;
    logic [31:0] message;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [5:0]  w_round;
    logic        w_last;

    int checks = 0;
    int errors = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    message_schedule_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .round    (round),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .addr_c   (addr_c),
        .addr_d   (addr_d),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .message  (message),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_round  (w_round),
        .w_last   (w_last)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Behavioural schedule datapath driven by the DUT's round.
    assign addr_a  = (round < 6'd16) ? round : round - 6'd15;
    assign addr_b  = round - 6'd2;
    assign addr_c  = round - 6'd16;
    assign addr_d  = round - 6'd7;
    assign message = (round < 6'd16) ? a : sig1(b) + d + sig0(a) + c;

    task automatic build_model();
        for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_model();
    endtask

    // Feed the 16 block words, optionally with random in_valid gaps.
    task automatic load_block(input bit gaps);
        int acc = 0;
        int cyc = 0;
        while (acc < 16 && cyc < 200) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = blk[acc];
            w_ready  = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_in_ready word=%0d got=%b exp=1", acc, in_ready);
            end
            if (in_valid) acc++;
            cyc++;
        end
        checks++;
        if (acc != 16) begin
            errors++;
            $display("FAIL load_timeout accepted=%0d exp=16", acc);
        end
    endtask

    // Consume one W stream. mode: 0 ready high, 1 toggle, 2 random.
    // stop_at >= 0 returns while that round is presented, before it is taken.
    task automatic stream(input int mode, input bit junk, input int stop_at, input bit post);
        int          idx = 0;
        int          cyc = 0;
        int          cnt = 0;
        int          last_c = -1;
        bit          started = 1'b0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic [5:0]  prev_r = '0;
        while (idx < 64 && cyc < 600) begin
            @(negedge clk);
            if (!started && w_valid) begin
                started = 1'b1;
                cnt = 0;
            end else if (started) begin
                cnt++;
            end
            case (mode)
                0:       w_ready = 1'b1;
                1:       w_ready = started ? cnt[0] : 1'b0;
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid = junk && !in_ready;
            in_data  = $urandom;
            #1;
            if (w_valid) begin
                if (stop_at >= 0 && idx == stop_at) return;
                checks++;
                if ({w_data, w_round, w_last} !== {exp_w[idx], 6'(idx), (idx == 63)}) begin
                    errors++;
                    $display("FAIL stream_word idx=%0d got data=%h round=%0d last=%b exp data=%h round=%0d last=%b",
                             idx, w_data, w_round, w_last, exp_w[idx], idx, (idx == 63));
                end
                if (prev_stall) begin
                    checks++;
                    if (w_data !== prev_d || w_round !== prev_r) begin
                        errors++;
                        $display("FAIL stall_hold got data=%h round=%0d exp data=%h round=%0d",
                                 w_data, w_round, prev_d, prev_r);
                    end
                end
                if (!w_last) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL run_in_ready idx=%0d got=%b exp=0", idx, in_ready);
                    end
                end
                prev_stall = !w_ready;
                prev_d     = w_data;
                prev_r     = w_round;
                if (w_ready) begin
                    got_w[idx] = w_data;
                    if (idx == 63) last_c = cnt;
                    idx++;
                end
            end else begin
                if (prev_stall) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_withdrawn got w_valid=0 exp 1 idx=%0d", idx);
                end
                prev_stall = 1'b0;
            end
            cyc++;
        end
        checks++;
        if (idx != 64) begin
            errors++;
            $display("FAIL stream_timeout beats=%0d exp=64", idx);
        end
        if (mode == 0 || mode == 1) begin
            checks++;
            if (last_c + 1 != (mode == 0 ? 64 : 128)) begin
                errors++;
                $display("FAIL stream_cycles got=%0d exp=%0d", last_c + 1, (mode == 0 ? 64 : 128));
            end
        end
        if (post) begin
            @(negedge clk);
            in_valid = 1'b0;
            w_ready  = 1'b1;
            #1;
            checks++;
            if (w_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_last got w_valid=%b in_ready=%b exp w_valid=0 in_ready=1",
                         w_valid, in_ready);
            end
        end
    endtask

    task automatic check_abc_words();
        checks++;
        if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018 ||
            got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000 ||
            got_w[63] !== 32'h12B1EDEB) begin
            errors++;
            $display("FAIL abc_known got W0=%h W15=%h W16=%h W17=%h W63=%h exp 61626380 00000018 61626380 000f0000 12b1edeb",
                     got_w[0], got_w[15], got_w[16], got_w[17], got_w[63]);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        w_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || w_valid !== 1'b0 || round !== 6'd0 || w_last !== 1'b0 ||
            w_data !== 32'h0 || w_round !== 6'd0) begin
            errors++;
            $display("FAIL reset_state got in_ready=%b w_valid=%b round=%0d w_last=%b w_data=%h w_round=%0d exp 1 0 0 0 0 0",
                     in_ready, w_valid, round, w_last, w_data, w_round);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_abc();
        set_abc();
        load_block(1'b0);
        stream(0, 1'b0, -1, 1'b1);
        check_abc_words();
    endtask

    task automatic test_stall();
        set_abc();
        load_block(1'b0);
        stream(1, 1'b0, -1, 1'b1);
        check_abc_words();
    endtask

    task automatic test_junk();
        set_abc();
        load_block(1'b0);
        stream(0, 1'b1, -1, 1'b1);
        check_abc_words();
        set_random();
        load_block(1'b1);
        stream(2, 1'b1, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            set_random();
            load_block(1'b1);
            stream(2, 1'b0, -1, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        set_random();
        load_block(1'b0);
        stream(0, 1'b0, 30, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || w_valid !== 1'b0 || round !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid got in_ready=%b w_valid=%b round=%0d exp 1 0 0",
                     in_ready, w_valid, round);
        end
        set_abc();
        load_block(1'b0);
        stream(0, 1'b0, -1, 1'b1);
        check_abc_words();
    endtask

    task automatic test_back_to_back();
        set_random();
        load_block(1'b0);
        stream(0, 1'b0, -1, 1'b0);
        set_random();
        load_block(1'b0);
        stream(0, 1'b0, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stall();
        test_junk();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
